// File: rtl/cv32e40p_cg_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cv32e40p_cg_ctrl : idle-driven clock-gate controller (RUN/GATED/WAKE)     |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module cv32e40p_cg_ctrl #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned IDLE_CYCLES = 8,
  parameter int unsigned WAKE_CYCLES = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] busy_i,
  input  logic               force_en_i,
  input  logic               cnt_clr_i,
  output logic               cg_en_o,
  output logic               clk_ready_o,
  output logic               gated_o,
  output logic [15:0]        gated_cycles_o
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    GATED = 2'd1,
    WAKE  = 2'd2
  } state_e;

  localparam logic [7:0] IDLE_LAST = 8'(IDLE_CYCLES - 1);
  localparam logic [7:0] WAKE_LAST = 8'(WAKE_CYCLES - 1);

  state_e      state_q;
  logic [7:0]  idle_cnt_q;
  logic [7:0]  wake_cnt_q;
  logic        cg_en_q;
  logic        clk_ready_q;
  logic        gated_q;
  logic [15:0] gated_cnt_q;
  logic [15:0] gated_cnt_d;
  logic        idle_cycle;

  assign idle_cycle = ~(|busy_i) & ~force_en_i;

  // Outputs are registered alongside the state so they change on the same
  // edge as the transition and never see a combinational path from inputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      idle_cnt_q  <= '0;
      wake_cnt_q  <= '0;
      cg_en_q     <= 1'b1;
      clk_ready_q <= 1'b1;
      gated_q     <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (!idle_cycle) begin
            idle_cnt_q <= '0;
          end else if (idle_cnt_q == IDLE_LAST) begin
            state_q     <= GATED;
            idle_cnt_q  <= '0;
            cg_en_q     <= 1'b0;
            clk_ready_q <= 1'b0;
            gated_q     <= 1'b1;
          end else begin
            idle_cnt_q <= idle_cnt_q + 8'd1;
          end
        end
        GATED: begin
          if (!idle_cycle) begin
            state_q    <= WAKE;
            wake_cnt_q <= '0;
            cg_en_q    <= 1'b1;
            gated_q    <= 1'b0;
          end
        end
        WAKE: begin
          // Wake latency is fixed; requester activity cannot shorten or re-gate it.
          if (wake_cnt_q == WAKE_LAST) begin
            state_q     <= RUN;
            idle_cnt_q  <= '0;
            clk_ready_q <= 1'b1;
          end else begin
            wake_cnt_q <= wake_cnt_q + 8'd1;
          end
        end
        default: begin
          state_q     <= RUN;
          idle_cnt_q  <= '0;
          wake_cnt_q  <= '0;
          cg_en_q     <= 1'b1;
          clk_ready_q <= 1'b1;
          gated_q     <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    gated_cnt_d = gated_cnt_q;
    if (cnt_clr_i) begin
      gated_cnt_d = '0;
    end else if ((state_q == GATED) && (gated_cnt_q != 16'hFFFF)) begin
      gated_cnt_d = gated_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gated_cnt_q <= '0;
    end else begin
      gated_cnt_q <= gated_cnt_d;
    end
  end

  assign cg_en_o        = cg_en_q;
  assign clk_ready_o    = clk_ready_q;
  assign gated_o        = gated_q;
  assign gated_cycles_o = gated_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_cv32e40p_cg_ctrl.sv
`default_nettype none
// Self-checking bench for cv32e40p_cg_ctrl: timestamp-based reference model
// compared every cycle, plus directed literal checks and randomized traffic.
module tb_cv32e40p_cg_ctrl;

  localparam int NUM_REQ     = 4;
  localparam int IDLE_CYCLES = 8;
  localparam int WAKE_CYCLES = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [NUM_REQ-1:0] busy;
  logic               force_en;
  logic               cnt_clr;
  logic               cg_en;
  logic               clk_ready;
  logic               gated;
  logic [15:0]        gated_cycles;

  int checks = 0;
  int errors = 0;

  cv32e40p_cg_ctrl #(
    .NUM_REQ    (NUM_REQ),
    .IDLE_CYCLES(IDLE_CYCLES),
    .WAKE_CYCLES(WAKE_CYCLES)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .busy_i        (busy),
    .force_en_i    (force_en),
    .cnt_clr_i     (cnt_clr),
    .cg_en_o       (cg_en),
    .clk_ready_o   (clk_ready),
    .gated_o       (gated),
    .gated_cycles_o(gated_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode plus cycle timestamps; wake ends a fixed number of
  // cycles after the recorded start, gating after an idle streak of IDLE_CYCLES.
  localparam int M_RUN = 0, M_GATED = 1, M_WAKE = 2;
  int m_mode = M_RUN;
  int m_streak = 0;
  int m_t = 0;
  int m_wake_start = 0;
  int m_gc = 0;
  bit m_valid = 1'b0;
  bit is_idle;

  always @(posedge clk) begin
    m_t++;
    if (rst) begin
      m_mode   = M_RUN;
      m_streak = 0;
      m_gc     = 0;
      m_valid  = 1'b1;
    end else begin
      if (cnt_clr) m_gc = 0;
      else if (m_mode == M_GATED) m_gc = (m_gc < 65535) ? m_gc + 1 : 65535;
      is_idle = (busy == '0) && !force_en;
      case (m_mode)
        M_RUN: begin
          m_streak = is_idle ? m_streak + 1 : 0;
          if (m_streak == IDLE_CYCLES) begin
            m_mode   = M_GATED;
            m_streak = 0;
          end
        end
        M_GATED: if (!is_idle) begin
          m_mode       = M_WAKE;
          m_wake_start = m_t + 1;
        end
        default: if (m_t - m_wake_start + 1 == WAKE_CYCLES) begin
          m_mode   = M_RUN;
          m_streak = 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("cg_en", int'(cg_en), (m_mode != M_GATED) ? 1 : 0);
      chk("clk_ready", int'(clk_ready), (m_mode == M_RUN) ? 1 : 0);
      chk("gated", int'(gated), (m_mode == M_GATED) ? 1 : 0);
      chk("gated_cycles", int'(gated_cycles), m_gc);
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; busy = '0; force_en = 1'b0; cnt_clr = 1'b0;
    tick(3);
    chk("reset_cg_en", int'(cg_en), 1);
    chk("reset_ready", int'(clk_ready), 1);
    chk("reset_gated", int'(gated), 0);
    chk("reset_gc", int'(gated_cycles), 0);
    rst = 1'b0;

    // Gate after exactly 8 idle cycles, then count 1,2,3
    tick(7);
    chk("idle7_cg_en", int'(cg_en), 1);
    tick(1);
    chk("idle8_cg_en", int'(cg_en), 0);
    chk("idle8_gated", int'(gated), 1);
    chk("gc_first", int'(gated_cycles), 0);
    tick(1); chk("gc_1", int'(gated_cycles), 1);
    tick(1); chk("gc_2", int'(gated_cycles), 2);
    tick(1); chk("gc_3", int'(gated_cycles), 3);

    // One-cycle busy pulse wakes; ready two cycles after cg_en
    busy = 4'b0100;
    tick(1);
    chk("wake_cg_en", int'(cg_en), 1);
    chk("wake_ready0", int'(clk_ready), 0);
    busy = '0;
    tick(1); chk("wake_ready1", int'(clk_ready), 0);
    tick(1); chk("wake_ready2", int'(clk_ready), 1);
    chk("wake_gated", int'(gated), 0);

    // Busy on 8th idle cycle cancels gating; a fresh 8-cycle streak is needed
    tick(7);
    busy = 4'b0001;
    tick(1);
    chk("late_busy_cg_en", int'(cg_en), 1);
    busy = '0;
    tick(7); chk("fresh7_cg_en", int'(cg_en), 1);
    tick(1); chk("fresh8_cg_en", int'(cg_en), 0);

    // Force wakes from GATED and holds the clock on
    force_en = 1'b1;
    tick(1);
    chk("force_cg_en", int'(cg_en), 1);
    chk("force_ready0", int'(clk_ready), 0);
    tick(2); chk("force_ready2", int'(clk_ready), 1);
    tick(100);
    chk("force100_cg_en", int'(cg_en), 1);
    force_en = 1'b0;

    // Saturation and clear
    tick(8);
    tick(70000);
    chk("gc_sat", int'(gated_cycles), 65535);
    cnt_clr = 1'b1;
    tick(1); chk("gc_clr", int'(gated_cycles), 0);
    cnt_clr = 1'b0;
    tick(1); chk("gc_after_clr", int'(gated_cycles), 1);

    // Reset during WAKE
    busy = 4'b1000;
    tick(1);
    busy = '0;
    rst = 1'b1;
    tick(1);
    chk("rst_wake_cg_en", int'(cg_en), 1);
    chk("rst_wake_ready", int'(clk_ready), 1);
    chk("rst_wake_gc", int'(gated_cycles), 0);
    rst = 1'b0;

    // Reset during GATED
    tick(8 + 3);
    chk("pre_rst_gated", int'(gated), 1);
    rst = 1'b1;
    tick(1);
    chk("rst_gated_cg_en", int'(cg_en), 1);
    chk("rst_gated_ready", int'(clk_ready), 1);
    chk("rst_gated_gc", int'(gated_cycles), 0);
    rst = 1'b0;

    // Randomized traffic, biased toward idle so gating and waking both occur
    for (int i = 0; i < 3000; i++) begin
      busy     = ($urandom_range(0, 9) == 0) ? NUM_REQ'($urandom) : '0;
      force_en = ($urandom_range(0, 49) == 0);
      cnt_clr  = ($urandom_range(0, 99) == 0);
      rst      = ($urandom_range(0, 499) == 0);
      tick(1);
    end
    rst = 1'b0; busy = '0; force_en = 1'b0; cnt_clr = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cv32e40p_cg_ctrl.md
CV32E40P_CG_CTRL -- requirements
Module: cv32e40p_cg_ctrl

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning the number of requester busy lines (range 1..16).
REQ-002 SHALL have parameter IDLE_CYCLES, default 8, meaning the consecutive idle cycles required before gating (range 1..255).
REQ-003 SHALL have parameter WAKE_CYCLES, default 2, meaning the cycles the clock runs before clk_ready_o asserts after wake (range 1..255).
REQ-004 SHALL have port clk_i, input, 1, free-running (ungated) clock; all logic runs on rising edge.
REQ-005 SHALL have port rst_i, input, 1; reset is synchronous and active-high.
REQ-006 SHALL have port busy_i, input, NUM_REQ, per-requester activity flags, sourced from the ungated domain.
REQ-007 SHALL have port force_en_i, input, 1, debug/test override that holds or brings the clock on.
REQ-008 SHALL have port cnt_clr_i, input, 1, synchronous clear of the gated-cycle counter.
REQ-009 SHALL have port cg_en_o, input-side enable to the clock-gate cell, output, 1, registered.
REQ-010 SHALL have port clk_ready_o, output, 1, registered, gated clock stable and usable by requesters.
REQ-011 SHALL have port gated_o, output, 1, registered, high while in GATED state.
REQ-012 SHALL have port gated_cycles_o, output, 16, registered, saturating count of cycles spent in GATED.

Function
REQ-013 SHALL implement states RUN, GATED, WAKE; encoding is free; outputs are decoded from registered state only (no combinational path from inputs to outputs).
REQ-014 SHALL drive in RUN: cg_en_o=1, clk_ready_o=1, gated_o=0.
REQ-015 SHALL drive in GATED: cg_en_o=0, clk_ready_o=0, gated_o=1.
REQ-016 SHALL drive in WAKE: cg_en_o=1, clk_ready_o=0, gated_o=0.
REQ-017 SHALL define idle cycle = (busy_i == 0) and force_en_i == 0.
REQ-018 SHALL in RUN keep an idle counter (8 bit): increment on idle cycle, clear to 0 on any non-idle cycle.
REQ-019 SHALL in RUN transition to GATED at the edge ending the IDLE_CYCLES-th consecutive idle cycle; gated_o/cg_en_o change on that edge (first GATED cycle is the cycle after the last idle cycle).
REQ-020 SHALL stay in RUN with idle counter 0 if a non-idle cycle coincides with the cycle that would otherwise expire the counter.
REQ-021 SHALL in GATED transition to WAKE on the edge ending any cycle with busy_i != 0 or force_en_i == 1.
REQ-022 SHALL in WAKE count WAKE_CYCLES cycles (counter loaded 0 on WAKE entry) and transition to RUN at the edge ending the WAKE_CYCLES-th WAKE cycle, regardless of busy_i or force_en_i during WAKE.
REQ-023 SHALL clear the idle counter on entry to RUN from WAKE.
REQ-024 SHALL increment gated_cycles_o once per cycle in GATED, saturating at 16'hFFFF (no wrap).
REQ-025 SHALL give cnt_clr_i priority over increment: counter reads 0 on the cycle after cnt_clr_i is high.
REQ-026 SHALL never pass from GATED to RUN without traversing WAKE, and never from WAKE to GATED directly.

Reset
REQ-027 SHALL on rst_i=1 at a rising edge set state=RUN, idle and wake counters=0, gated_cycles_o=0, hence cg_en_o=1, clk_ready_o=1, gated_o=0 on the following cycle.
REQ-028 SHALL honour reset from any state, including mid-WAKE or GATED, with reset overriding all other inputs.

Verification
REQ-029 SHALL test: defaults, busy_i=0 from reset release -> cg_en_o falls after exactly 8 idle cycles, gated_o=1, gated_cycles_o counts 1,2,3...
REQ-030 SHALL test: in GATED pulse busy_i[2] one cycle -> cg_en_o=1 next cycle, clk_ready_o=1 exactly 2 cycles later, state RUN.
REQ-031 SHALL test: idle for 7 cycles then busy_i[0]=1 on the 8th -> stays RUN, cg_en_o never drops; 8 fresh idle cycles required afterwards.
REQ-032 SHALL test: force_en_i=1 with busy_i=0 for 100 cycles -> never gates; force in GATED -> wake as REQ-030.
REQ-033 SHALL test: gated for 70000 cycles -> gated_cycles_o=16'hFFFF; cnt_clr_i with gating active -> 0 next cycle, then increments.
REQ-034 SHALL test: rst_i asserted during WAKE and during GATED -> next cycle cg_en_o=1, clk_ready_o=1, gated_cycles_o=0.
